// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: request sequencer in front of a synchronous single-port memory.
// Takes one read or write at a time over a valid/ready request channel.
// It drives the memory pins from registers, so read and write are never high together.
// Read data comes back on a valid/ready response channel.
// A read to an address >= DEPTH returns rsp_err=1 and rsp_rdata=0.
// A write to an address >= DEPTH is dropped without touching the memory.
// Optional feature macro: MEMCTL_INIT_EN. When it is defined, the controller runs a
// post-reset sweep that writes INIT_VALUE to every location before it accepts requests.
module mem_req_ctrl #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH) || $bits(INIT_VALUE) != DATA_WIDTH) begin : g_bad_params
    $error("mem_req_ctrl: DEPTH must lie in 1..2**ADDR_WIDTH and INIT_VALUE must be DATA_WIDTH wide");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    RDCAP = 3'd3,
`ifdef MEMCTL_INIT_EN
    RSP   = 3'd4,
    INIT  = 3'd5
`else
    RSP   = 3'd4
`endif
  } state_t;

`ifdef MEMCTL_INIT_EN
  localparam state_t RESET_STATE = INIT;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  // One extra bit so that DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state, nx_state;
  logic                  nx_mem_read, nx_mem_write;
  logic [ADDR_WIDTH-1:0] nx_mem_addr;
  logic [DATA_WIDTH-1:0] nx_mem_data_in, nx_rsp_rdata;
  logic                  nx_rsp_err;
  logic                  in_range;
`ifdef MEMCTL_INIT_EN
  logic [ADDR_WIDTH:0]   init_cnt, nx_init_cnt;
`endif

  assign in_range = ({1'b0, req_addr} < DEPTH_L);

  // Next state and next values of every registered output; memory pins default to idle/hold.
  always_comb begin
    nx_state       = state;
    nx_mem_read    = 1'b0;
    nx_mem_write   = 1'b0;
    nx_mem_addr    = mem_addr;
    nx_mem_data_in = mem_data_in;
    nx_rsp_rdata   = rsp_rdata;
    nx_rsp_err     = rsp_err;
`ifdef MEMCTL_INIT_EN
    nx_init_cnt    = init_cnt;
`endif
    case (state)
`ifdef MEMCTL_INIT_EN
      INIT: begin
        if (init_cnt == DEPTH_L) begin
          nx_state = IDLE;
        end else begin
          nx_mem_write   = 1'b1;
          nx_mem_addr    = init_cnt[ADDR_WIDTH-1:0];
          nx_mem_data_in = INIT_VALUE;
          nx_init_cnt    = init_cnt + (ADDR_WIDTH+1)'(1);
        end
      end
`endif
      IDLE: begin
        if (req_valid && req_ready) begin
          if (!in_range) begin
            // Out-of-range write is dropped; out-of-range read answers with an error.
            if (!req_wr) begin
              nx_state     = RSP;
              nx_rsp_err   = 1'b1;
              nx_rsp_rdata = '0;
            end
          end else begin
            nx_mem_addr = req_addr;
            if (req_wr) begin
              nx_state       = WR;
              nx_mem_write   = 1'b1;
              nx_mem_data_in = req_wdata;
            end else begin
              nx_state    = RD;
              nx_mem_read = 1'b1;
            end
          end
        end
      end
      WR:    nx_state = IDLE;
      RD:    nx_state = RDCAP;
      RDCAP: begin
        // Memory updated data_out on the edge that ended RD.
        nx_rsp_rdata = mem_data_out;
        nx_rsp_err   = 1'b0;
        nx_state     = RSP;
      end
      RSP: begin
        if (rsp_ready) nx_state = IDLE;
      end
      default: nx_state = IDLE;
    endcase
  end

  // State and output registers; reset clears everything, including any in-flight transaction.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state       <= RESET_STATE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      init_done   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
`ifdef MEMCTL_INIT_EN
      init_cnt    <= '0;
`endif
    end else begin
      state       <= nx_state;
      req_ready   <= (nx_state == IDLE);
      rsp_valid   <= (nx_state == RSP);
      rsp_rdata   <= nx_rsp_rdata;
      rsp_err     <= nx_rsp_err;
      mem_read    <= nx_mem_read;
      mem_write   <= nx_mem_write;
      mem_addr    <= nx_mem_addr;
      mem_data_in <= nx_mem_data_in;
`ifdef MEMCTL_INIT_EN
      init_cnt    <= nx_init_cnt;
      init_done   <= (nx_state != INIT);
`else
      init_done   <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: scoreboard bench for mem_req_ctrl.
// Instance 0 uses DEPTH=32 and instance 1 uses DEPTH=16. Each instance has its own
// synchronous 8x32 memory model. Honours MEMCTL_INIT_EN when it is defined.
module tb_mem_req_ctrl;

`ifdef MEMCTL_INIT_EN
  localparam int INIT_CYC0 = 32;
`else
  localparam int INIT_CYC0 = 0;
`endif
  localparam logic [7:0] INITV = 8'hFF;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_ = 1'b0;
  logic [1:0]      req_valid, req_ready, req_wr;
  logic [1:0][4:0] req_addr;
  logic [1:0][7:0] req_wdata;
  logic [1:0]      rsp_valid, rsp_ready, rsp_err, init_done;
  logic [1:0][7:0] rsp_rdata;
  logic [1:0]      mem_read, mem_write;
  logic [1:0][4:0] mem_addr;
  logic [1:0][7:0] mem_data_in, mem_data_out;

  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];

  exp_t sbq0[$];
  exp_t sbq1[$];
  int   passed = 0, total = 0;
  int   wr_cyc[2], rd_cyc[2];
  int   rw_viol = 0;

  always #5 clk = ~clk;

  mem_req_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .DEPTH(32), .INIT_VALUE(INITV)) u_dut0 (
    .clk(clk), .rst_(rst_),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .init_done(init_done[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
    .mem_data_in(mem_data_in[0]), .mem_data_out(mem_data_out[0])
  );

  mem_req_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .DEPTH(16), .INIT_VALUE(INITV)) u_dut1 (
    .clk(clk), .rst_(rst_),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .init_done(init_done[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
    .mem_data_in(mem_data_in[1]), .mem_data_out(mem_data_out[1])
  );

  // Synchronous memories: write and read on the clock edge.
  always @(posedge clk) begin
    if (mem_write[0]) mem_a[mem_addr[0]] <= mem_data_in[0];
    if (mem_read[0])  mem_data_out[0]    <= mem_a[mem_addr[0]];
    if (mem_write[1]) mem_b[mem_addr[1]] <= mem_data_in[1];
    if (mem_read[1])  mem_data_out[1]    <= mem_b[mem_addr[1]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  // Monitor: counts memory strobes and pops the scoreboard on each response handshake.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (mem_write[d]) wr_cyc[d]++;
      if (mem_read[d])  rd_cyc[d]++;
      if (mem_read[d] && mem_write[d]) rw_viol++;
      if (rst_ && rsp_valid[d] && rsp_ready[d]) begin
        if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
          total++;
          $display("FAIL rsp_unexpected dut%0d: got rdata %0h err %0b, required no response",
                   d, rsp_rdata[d], rsp_err[d]);
        end else begin
          e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
          chk($sformatf("rsp_rdata dut%0d", d), 32'(rsp_rdata[d]), 32'(e.data));
          chk($sformatf("rsp_err dut%0d", d), 32'(rsp_err[d]), 32'(e.err));
        end
      end
    end
  end

  task automatic send(input int d, input logic w, input logic [4:0] a, input logic [7:0] wd,
                      output bit ok);
    int n = 0;
    req_valid[d] = 1'b1; req_wr[d] = w; req_addr[d] = a; req_wdata[d] = wd;
    while (req_ready[d] !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    ok = (n < 200);
    if (!ok) begin
      total++;
      $display("FAIL req_accept_timeout dut%0d: got no req_ready, required accept of addr %0d", d, a);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic wr(input int d, input logic [4:0] a, input logic [7:0] wd);
    bit ok;
    send(d, 1'b1, a, wd, ok);
  endtask

  task automatic rd(input int d, input logic [4:0] a, input logic [7:0] ed, input logic ee,
                    input int elat);
    bit ok;
    int lat = 0;
    exp_t e;
    e.err = ee; e.data = ed;
    if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
    send(d, 1'b0, a, 8'h00, ok);
    if (!ok) return;
    while (rsp_valid[d] !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk($sformatf("rd_latency dut%0d addr%0d", d, a), 32'(lat), 32'(elat));
  endtask

  task automatic do_reset();
    int n = 0;
    rst_ = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b1;
    while (n < 100) begin
      @(posedge clk); #1;
      if (init_done[0] === 1'b1) break;
      n++;
    end
    chk("init_low_cycles", 32'(n), 32'(INIT_CYC0));
    chk("ready_after_init", 32'({req_ready[0], init_done[1], req_ready[1]}), 32'(3'b111));
  endtask

  initial begin
    int w0, r0, hold, stale;
    bit ok;
    req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0; rsp_ready = 2'b11;
    #1;
    chk("reset_outputs", 32'({req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0], init_done[0],
                              mem_read[0], mem_write[0], mem_addr[0], mem_data_in[0]}), 32'(0));
    @(posedge clk); #1;
    w0 = wr_cyc[0];
    do_reset();
    chk("init_write_cycles", 32'(wr_cyc[0] - w0), 32'(INIT_CYC0));
`ifdef MEMCTL_INIT_EN
    rd(0, 5'd10, INITV, 1'b0, 2);
    rd(0, 5'd31, INITV, 1'b0, 2);
    rd(1, 5'd15, INITV, 1'b0, 2);
`endif

    // Write then read back-to-back at the same address.
    w0 = wr_cyc[0]; r0 = rd_cyc[0];
    wr(0, 5'd3, 8'hA5);
    rd(0, 5'd3, 8'hA5, 1'b0, 2);
    chk("wr_pulse_cycles", 32'(wr_cyc[0] - w0), 32'(1));
    chk("rd_pulse_cycles", 32'(rd_cyc[0] - r0), 32'(1));

    // Response backpressure.
    wr(0, 5'd7, 8'h77);
    rsp_ready[0] = 1'b0;
    rd(0, 5'd7, 8'h77, 1'b0, 2);
    hold = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp_valid[0] === 1'b1 && rsp_rdata[0] === 8'h77 && req_ready[0] === 1'b0) hold++;
    end
    chk("bp_hold_cycles", 32'(hold), 32'(5));
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 32'({rsp_valid[0], req_ready[0]}), 32'(2'b01));

    // Asynchronous reset in the middle of a read.
    send(0, 1'b0, 5'd7, 8'h00, ok);
    chk("midread_mem_read", 32'({mem_read[0], mem_addr[0]}), 32'({1'b1, 5'd7}));
    #2 rst_ = 1'b0;
    #1;
    chk("midread_reset_outputs", 32'({req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0],
                                      init_done[0], mem_read[0], mem_write[0], mem_addr[0],
                                      mem_data_in[0]}), 32'(0));
    do_reset();
    stale = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid[0] !== 1'b0) stale++;
    end
    chk("no_stale_rsp", 32'(stale), 32'(0));

    // Fill and read back every location.
    for (int i = 0; i < 32; i++) wr(0, 5'(i), 8'(i) ^ 8'h5A);
    for (int i = 0; i < 32; i++) rd(0, 5'(i), 8'(i) ^ 8'h5A, 1'b0, 2);

    // Out-of-range accesses with DEPTH=16.
    wr(1, 5'd5, 8'h3C);
    rd(1, 5'd5, 8'h3C, 1'b0, 2);
    r0 = rd_cyc[1];
    rd(1, 5'd20, 8'h00, 1'b1, 0);
    repeat (2) @(posedge clk);
    #1 chk("err_no_mem_read", 32'(rd_cyc[1] - r0), 32'(0));
    w0 = wr_cyc[1];
    wr(1, 5'd20, 8'hEE);
    repeat (3) @(posedge clk);
    #1 chk("err_no_mem_write", 32'(wr_cyc[1] - w0), 32'(0));
    rd(1, 5'd16, 8'h00, 1'b1, 0);
    rd(1, 5'd15, (INIT_CYC0 != 0) ? INITV : mem_b[15], 1'b0, 2);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sbq0.size() + sbq1.size()), 32'(0));
    chk("rd_wr_exclusive", 32'(rw_viol), 32'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
